// File: rtl/vga_timing_if.sv
// Pixel-side bundle between the scan timing generator and the pixel generators / DAC.
// The master modport is the timing generator; the slave modport is the pixel-generator side.
interface vga_timing_if;
   logic        CE;
   logic [10:0] COL;
   logic [9:0]  ROW;
   logic        FRAME_START;
   logic [7:0]  R_IN;
   logic [7:0]  G_IN;
   logic [7:0]  B_IN;
   logic [7:0]  VGA_R;
   logic [7:0]  VGA_G;
   logic [7:0]  VGA_B;
   logic        VGA_HS;
   logic        VGA_VS;
   logic        VGA_DE;

   modport master (
      input  CE, R_IN, G_IN, B_IN,
      output COL, ROW, FRAME_START, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE
   );

   modport slave (
      output CE, R_IN, G_IN, B_IN,
      input  COL, ROW, FRAME_START, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE
   );
endinterface

// File: rtl/vga_timing.sv
// VGA scan timing generator: drives COL/ROW to the pixel generators and emits sync, DE and
// blanked colour to the DAC, delay-matched to the generator latency LAT.
module vga_timing #(
   parameter int unsigned H_ACT  = 800,
   parameter int unsigned H_FP   = 56,
   parameter int unsigned H_SYNC = 120,
   parameter int unsigned H_BP   = 64,
   parameter int unsigned V_ACT  = 600,
   parameter int unsigned V_FP   = 37,
   parameter int unsigned V_SYNC = 6,
   parameter int unsigned V_BP   = 23,
   parameter bit          HS_POL = 1'b1,
   parameter bit          VS_POL = 1'b1,
   parameter int unsigned LAT    = 1
) (
   input  logic          CLK,
   input  logic          RST,
   vga_timing_if.master  bus
);

   localparam int unsigned H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

   // Last count of each phase; the FSM leaves a phase when the counter sits on its last value.
   localparam logic [10:0] H_ACT_END  = 11'(H_ACT - 1);
   localparam logic [10:0] H_FP_END   = 11'(H_ACT + H_FP - 1);
   localparam logic [10:0] H_SYNC_END = 11'(H_ACT + H_FP + H_SYNC - 1);
   localparam logic [10:0] H_TOT_END  = 11'(H_TOT - 1);
   localparam logic [9:0]  V_ACT_END  = 10'(V_ACT - 1);
   localparam logic [9:0]  V_FP_END   = 10'(V_ACT + V_FP - 1);
   localparam logic [9:0]  V_SYNC_END = 10'(V_ACT + V_FP + V_SYNC - 1);
   localparam logic [9:0]  V_TOT_END  = 10'(V_TOT - 1);

   localparam logic [1:0] StActive = 2'd0;
   localparam logic [1:0] StFp     = 2'd1;
   localparam logic [1:0] StSync   = 2'd2;
   localparam logic [1:0] StBp     = 2'd3;

   logic [10:0] hcnt_q, hcnt_d;
   logic [9:0]  vcnt_q, vcnt_d;
   logic [1:0]  hst_q, hst_d;
   logic [1:0]  vst_q, vst_d;
   logic        h_wrap, v_wrap;
   logic        de_raw, hs_raw, vs_raw;
   logic [2:0]  flag_sr_q [LAT];
   logic        de_d, hs_d, vs_d;
   logic [7:0]  vga_r_q, vga_g_q, vga_b_q;
   logic        vga_hs_q, vga_vs_q, vga_de_q;

   assign h_wrap = (hcnt_q == H_TOT_END);
   assign v_wrap = (vcnt_q == V_TOT_END);

   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (bus.CE) begin
         hcnt_d = h_wrap ? 11'd0 : hcnt_q + 11'd1;
         if (h_wrap) begin
            vcnt_d = v_wrap ? 10'd0 : vcnt_q + 10'd1;
         end
      end
   end

   always_comb begin
      hst_d = hst_q;
      if (bus.CE) begin
         unique case (hst_q)
            StActive: if (hcnt_q == H_ACT_END)  hst_d = StFp;
            StFp:     if (hcnt_q == H_FP_END)   hst_d = StSync;
            StSync:   if (hcnt_q == H_SYNC_END) hst_d = StBp;
            StBp:     if (h_wrap)               hst_d = StActive;
            default:                            hst_d = StActive;
         endcase
      end
   end

   // Vertical phase steps only on the line wrap, so VSYNC edges land on hcnt=0.
   always_comb begin
      vst_d = vst_q;
      if (bus.CE && h_wrap) begin
         unique case (vst_q)
            StActive: if (vcnt_q == V_ACT_END)  vst_d = StFp;
            StFp:     if (vcnt_q == V_FP_END)   vst_d = StSync;
            StSync:   if (vcnt_q == V_SYNC_END) vst_d = StBp;
            StBp:     if (v_wrap)               vst_d = StActive;
            default:                            vst_d = StActive;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
         hst_q  <= StActive;
         vst_q  <= StActive;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
         hst_q  <= hst_d;
         vst_q  <= vst_d;
      end
   end

   assign de_raw = (hst_q == StActive) && (vst_q == StActive);
   assign hs_raw = (hst_q == StSync);
   assign vs_raw = (vst_q == StSync);

   // Flags ride a LAT-deep pipe so they meet the generator's registered colour.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < int'(LAT); i++) begin
            flag_sr_q[i] <= '0;
         end
      end else if (bus.CE) begin
         flag_sr_q[0] <= {de_raw, hs_raw, vs_raw};
         for (int i = 1; i < int'(LAT); i++) begin
            flag_sr_q[i] <= flag_sr_q[i-1];
         end
      end
   end

   assign {de_d, hs_d, vs_d} = flag_sr_q[LAT-1];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         vga_r_q  <= '0;
         vga_g_q  <= '0;
         vga_b_q  <= '0;
         vga_de_q <= 1'b0;
         vga_hs_q <= ~HS_POL;
         vga_vs_q <= ~VS_POL;
      end else if (bus.CE) begin
         vga_r_q  <= de_d ? bus.R_IN : 8'd0;
         vga_g_q  <= de_d ? bus.G_IN : 8'd0;
         vga_b_q  <= de_d ? bus.B_IN : 8'd0;
         vga_de_q <= de_d;
         vga_hs_q <= hs_d ? HS_POL : ~HS_POL;
         vga_vs_q <= vs_d ? VS_POL : ~VS_POL;
      end
   end

   assign bus.COL         = hcnt_q;
   assign bus.ROW         = vcnt_q;
   // Gated by RST so the pulse is low while reset is held.
   assign bus.FRAME_START = RST && bus.CE && (hcnt_q == 11'd0) && (vcnt_q == 10'd0);
   assign bus.VGA_R       = vga_r_q;
   assign bus.VGA_G       = vga_g_q;
   assign bus.VGA_B       = vga_b_q;
   assign bus.VGA_DE      = vga_de_q;
   assign bus.VGA_HS      = vga_hs_q;
   assign bus.VGA_VS      = vga_vs_q;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing on a reduced 30x15 raster with a LAT-deep stub pixel
// generator; every CE edge pushes the expected outputs of the newly presented pixel.
module tb_vga_timing;

   localparam int H_ACT  = 16;
   localparam int H_FP   = 4;
   localparam int H_SYNC = 6;
   localparam int H_BP   = 4;
   localparam int V_ACT  = 8;
   localparam int V_FP   = 2;
   localparam int V_SYNC = 2;
   localparam int V_BP   = 3;
   localparam int H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int FRAME  = H_TOT * V_TOT;
   localparam bit HS_POL = 1'b1;
   localparam bit VS_POL = 1'b0;
   localparam int LAT    = 2;

   typedef struct packed {
      logic       de;
      logic       hs;
      logic       vs;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   vga_timing_if bus ();

   vga_timing #(
      .H_ACT (H_ACT), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACT (V_ACT), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .HS_POL (HS_POL), .VS_POL (VS_POL), .LAT (LAT)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   // Stub pixel generator: registers {COL,ROW} through LAT CE-gated stages.
   logic [20:0] gen_q [LAT];
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < LAT; i++) gen_q[i] <= '0;
      end else if (bus.CE) begin
         gen_q[0] <= {bus.COL, bus.ROW};
         for (int i = 1; i < LAT; i++) gen_q[i] <= gen_q[i-1];
      end
   end
   assign bus.R_IN = gen_q[LAT-1][17:10];
   assign bus.G_IN = gen_q[LAT-1][7:0];
   assign bus.B_IN = gen_q[LAT-1][17:10] ^ gen_q[LAT-1][7:0];

   exp_t q[$];
   exp_t cur;
   exp_t rst_t;
   int   compared   = 0;
   int   mismatched = 0;
   int   mh, mv;
   int   ce_cyc;
   int   fs_last;
   int   de_cnt, hs_cnt, vs_cnt;

   function automatic exp_t pix(int h, int v);
      exp_t e;
      e.de = (h < H_ACT) && (v < V_ACT);
      e.hs = (h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
      e.vs = (v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
      e.r  = e.de ? 8'(h) : 8'd0;
      e.g  = e.de ? 8'(v) : 8'd0;
      e.b  = e.de ? (8'(h) ^ 8'(v)) : 8'd0;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input bit ce);
      chk("col", 32'(bus.COL), 32'(mh));
      chk("row", 32'(bus.ROW), 32'(mv));
      chk("frame_start", 32'(bus.FRAME_START), 32'(RST && ce && mh == 0 && mv == 0));
      chk("de", 32'(bus.VGA_DE), 32'(cur.de));
      chk("hs", 32'(bus.VGA_HS), 32'(cur.hs));
      chk("vs", 32'(bus.VGA_VS), 32'(cur.vs));
      chk("r", 32'(bus.VGA_R), 32'(cur.r));
      chk("g", 32'(bus.VGA_G), 32'(cur.g));
      chk("b", 32'(bus.VGA_B), 32'(cur.b));
   endtask

   task automatic reset_model();
      mh = 0;
      mv = 0;
      q.delete();
      for (int i = 0; i < LAT; i++) q.push_back(rst_t);
      q.push_back(pix(0, 0));
      cur = rst_t;
   endtask

   task automatic step(input bit ce);
      @(negedge CLK);
      bus.CE = ce;
      #1;
      check_all(ce);
      if (ce) begin
         if (bus.FRAME_START) begin
            if (fs_last >= 0) chk("frame_period", 32'(ce_cyc - fs_last), 32'(FRAME));
            fs_last = ce_cyc;
         end
         if (ce_cyc >= FRAME && ce_cyc < 2 * FRAME) begin
            if (bus.VGA_DE) de_cnt++;
            if (bus.VGA_HS == HS_POL) hs_cnt++;
            if (bus.VGA_VS == VS_POL) vs_cnt++;
         end
         ce_cyc++;
      end
      @(posedge CLK);
      if (ce) begin
         mh++;
         if (mh == H_TOT) begin
            mh = 0;
            mv++;
            if (mv == V_TOT) mv = 0;
         end
         q.push_back(pix(mh, mv));
         cur = q.pop_front();
      end
   endtask

   initial begin
      bit found;
      rst_t = '{de: 1'b0, hs: ~HS_POL, vs: ~VS_POL, r: 8'd0, g: 8'd0, b: 8'd0};
      fs_last = -1;
      ce_cyc  = 0;
      de_cnt  = 0;
      hs_cnt  = 0;
      vs_cnt  = 0;
      bus.CE  = 1'b0;
      reset_model();

      // Reset held with CE active: nothing moves, FRAME_START stays low.
      repeat (3) @(negedge CLK);
      bus.CE = 1'b1;
      #1;
      check_all(1'b1);
      @(negedge CLK);
      bus.CE = 1'b0;
      RST    = 1'b1;

      // Two full frames plus a margin at full rate.
      for (int i = 0; i < 2 * FRAME + 10; i++) step(1'b1);
      chk("de_per_frame", 32'(de_cnt), 32'(H_ACT * V_ACT));
      chk("hs_per_frame", 32'(hs_cnt), 32'(H_SYNC * V_TOT));
      chk("vs_per_frame", 32'(vs_cnt), 32'(V_SYNC * H_TOT));

      // Half rate, then random CE.
      for (int i = 0; i < FRAME + 20; i++) begin
         step(1'b1);
         step(1'b0);
      end
      for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 1)));

      // Mid-frame asynchronous reset.
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
         if (mh == H_ACT / 2 && mv == V_ACT / 2) found = 1'b1;
         else step(1'b1);
      end
      chk("reach_mid_frame", 32'(found), 32'd1);
      @(negedge CLK);
      bus.CE = 1'b1;
      #2;
      RST = 1'b0;
      #1;
      reset_model();
      check_all(1'b1);
      @(negedge CLK);
      #1;
      check_all(1'b1);
      bus.CE = 1'b0;
      RST    = 1'b1;
      fs_last = -1;
      for (int i = 0; i < 3 * H_TOT; i++) step(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
